// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and frame constants shared by the UART receive path
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int DATA_BITS = 8;
  localparam int RATE_MIN = 4;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: per-frame bit-period down-counter; loadHalf latches rate and aims the first expiry mid start bit
module uart_bit_timer #(
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [RATE_W-1:0] rate,
  input  logic              loadHalf,
  output logic              expire
);
  logic [RATE_W-1:0] latchedRate;
  logic [RATE_W-1:0] cnt;
  assign expire = cnt == '0;
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      latchedRate <= '0;
      cnt         <= '0;
    end else if (loadHalf) begin
      latchedRate <= rate;
      cnt         <= (rate >> 1) - 1'b1;
    end else begin
      cnt <= expire ? latchedRate - 1'b1 : cnt - 1'b1;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receive framer with one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parityError port.
module uart_rx import uart_pkg::*; #(
  parameter int RATE_W    = 16,
  parameter int DATA_BITS = uart_pkg::DATA_BITS
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [RATE_W-1:0] rate,
  input  logic              in,
  input  logic              inFall,
  output logic [7:0]        data,
  output logic              valid,
  input  logic              ready,
  output logic              framingError,
  output logic              overrun,
  output logic              busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic              parityError
`endif
);
  if (DATA_BITS != 8) begin : g_bits_check
    $error("uart_rx supports DATA_BITS=8 only");
  end
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic parBit;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t     state, stateNext;
  logic       expire, loadHalf;
  logic [2:0] bitIdx;
  logic [7:0] shift;
  // A fall only starts a frame from IDLE; one coinciding with the STOP sample is dropped
  assign loadHalf = state == IDLE && inFall;
  assign busy     = state != IDLE;
  uart_bit_timer #(.RATE_W(RATE_W)) u_timer (
    .clk      (clk),
    .nReset   (nReset),
    .rate     (rate),
    .loadHalf (loadHalf),
    .expire   (expire)
  );
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) state <= IDLE;
    else         state <= stateNext;
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    stateNext = inFall ? START : IDLE;
      START:   stateNext = expire ? (in ? IDLE : DATA) : START;
      DATA:    stateNext = expire && bitIdx == 3'd7 ? AFTER_DATA : DATA;
      PARITY:  stateNext = expire ? STOP : PARITY;
      STOP:    stateNext = expire ? IDLE : STOP;
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      bitIdx       <= '0;
      shift        <= '0;
      data         <= '0;
      valid        <= 1'b0;
      framingError <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parBit       <= 1'b0;
      parityError  <= 1'b0;
`endif
    end else begin
      framingError <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityError  <= 1'b0;
      if (expire && state == PARITY) parBit <= in;
`endif
      if (valid && ready) valid <= 1'b0;
      if (expire && state == START) bitIdx <= '0;
      if (expire && state == DATA) begin
        shift  <= {in, shift[7:1]};
        bitIdx <= bitIdx + 1'b1;
      end
      if (expire && state == STOP) begin
        if (!in) framingError <= 1'b1;
        else if (valid && !ready) overrun <= 1'b1;
        else begin
          data  <= shift;
          valid <= 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        parityError <= parBit != ^shift;
`endif
      end
    end
endmodule
